wb_arbiter: RTL

Write-back arbiter and pending-write scoreboard for the integer general register file (32 × XLEN, single write port, two read ports). It shares the one register-file write port between the ALU write-back path and the load/store unit (LSU) write-back path. Each path has a one-entry holding register, and a round-robin grant chooses between them. The block also keeps a 32-bit busy vector of destination registers with writes in flight, which the decode stage uses for RAW hazard stalls.

---
 rtl/wb_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the integer register file: two one-entry holding registers,
// round-robin grant onto the single write port, and a pending-write busy scoreboard.
module wb_arbiter #(
    parameter int XLEN           = 32,
    parameter int XREG_ADDRWIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_alu_valid,
    input  logic [XREG_ADDRWIDTH-1:0] i_alu_addr,
    input  logic [XLEN-1:0]           i_alu_data,
    output logic                      o_alu_ready,
    input  logic                      i_lsu_valid,
    input  logic [XREG_ADDRWIDTH-1:0] i_lsu_addr,
    input  logic [XLEN-1:0]           i_lsu_data,
    output logic                      o_lsu_ready,
    input  logic                      i_issue_valid,
    input  logic [XREG_ADDRWIDTH-1:0] i_issue_addr,
    output logic                      o_write_flag,
    output logic [XREG_ADDRWIDTH-1:0] o_write_addr,
    output logic [XLEN-1:0]           o_write_data,
    output logic [31:0]               o_busy
);

    typedef enum logic {GNT_ALU = 1'b0, GNT_LSU = 1'b1} gnt_e;

    gnt_e                      last_q, last_d;
    logic                      alu_v, lsu_v;
    logic [XREG_ADDRWIDTH-1:0] alu_addr, lsu_addr;
    logic [XLEN-1:0]           alu_data, lsu_data;
    logic                      grant_alu, grant_lsu;
    logic                      alu_zero, lsu_zero;
    logic                      alu_load, lsu_load;
    logic [31:0]               busy_d;

    // Last-grant pointer: state register / next-state / grant decode
    always_ff @(posedge clk) begin
        if (rst) last_q <= GNT_LSU;
        else     last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (grant_alu)      last_d = GNT_ALU;
        else if (grant_lsu) last_d = GNT_LSU;
    end

    always_comb begin
        grant_alu = alu_v && (!lsu_v || (last_q == GNT_LSU));
        grant_lsu = lsu_v && (!alu_v || (last_q == GNT_ALU));
    end

    // x0 requests are swallowed: always ready, never held
    always_comb begin
        alu_zero    = (i_alu_addr == '0);
        lsu_zero    = (i_lsu_addr == '0);
        o_alu_ready = alu_zero || !alu_v || grant_alu;
        o_lsu_ready = lsu_zero || !lsu_v || grant_lsu;
        alu_load    = i_alu_valid && o_alu_ready && !alu_zero;
        lsu_load    = i_lsu_valid && o_lsu_ready && !lsu_zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_v    <= 1'b0;
            alu_addr <= '0;
            alu_data <= '0;
        end else if (alu_load) begin
            alu_v    <= 1'b1;
            alu_addr <= i_alu_addr;
            alu_data <= i_alu_data;
        end else if (grant_alu) begin
            alu_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_v    <= 1'b0;
            lsu_addr <= '0;
            lsu_data <= '0;
        end else if (lsu_load) begin
            lsu_v    <= 1'b1;
            lsu_addr <= i_lsu_addr;
            lsu_data <= i_lsu_data;
        end else if (grant_lsu) begin
            lsu_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_write_flag <= 1'b0;
            o_write_addr <= '0;
            o_write_data <= '0;
        end else if (grant_alu) begin
            o_write_flag <= 1'b1;
            o_write_addr <= alu_addr;
            o_write_data <= alu_data;
        end else if (grant_lsu) begin
            o_write_flag <= 1'b1;
            o_write_addr <= lsu_addr;
            o_write_data <= lsu_data;
        end else begin
            o_write_flag <= 1'b0;
        end
    end

    // Set is applied after clear so a newly issued writer keeps the bit
    always_comb begin
        busy_d = o_busy;
        if (o_write_flag) busy_d[o_write_addr] = 1'b0;
        if (i_issue_valid && (i_issue_addr != '0)) busy_d[i_issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) o_busy <= '0;
        else     o_busy <= busy_d;
    end

endmodule
